// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline.
// Holds the IF/ID bundle and fetch-stage defaults.
package mips_pkg;

    localparam int          PC_W           = 32;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam int          DEF_IMEM_WORDS = 1024;

    // IF/ID pipeline register contents
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

    // A bubble is a NOP with zeroed PCs and valid cleared
    localparam if_id_t IF_ID_BUBBLE = '{
        instr: NOP_INSTR,
        pc:    32'h0,
        pc4:   32'h0,
        valid: 1'b0
    };

    // Word index into a power-of-two memory; high PC bits wrap away
    function automatic logic [31:0] word_index(
        input logic [PC_W-1:0] pc,
        input int              words
    );
        logic [31:0] mask;
        mask = 32'(words - 1);
        return (pc >> 2) & mask;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Bubble has priority over load; reset leaves a bubble.
module if_id_reg
    import mips_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   bubble,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t r_q;

    // Capture a new fetch, insert a bubble, or hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= IF_ID_BUBBLE;
        end else if (bubble) begin
            r_q <= IF_ID_BUBBLE;
        end else if (load) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, redirect/stall/flush priority, IF/ID capture.
// Reads a combinational instruction memory once per cycle.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter int          IMEM_WORDS = DEF_IMEM_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_next;
    logic [PC_W-1:0] w_pc_plus4;
    logic [PC_W-1:0] w_redirect_tgt;
    logic            w_bubble;
    logic            w_load;
    logic            w_misalign;
    logic            r_misalign;
    logic [31:0]     r_fetch_count;
    if_id_t          w_d;
    if_id_t          w_q;

    assign w_pc_plus4     = r_pc + 32'd4;
    assign w_redirect_tgt = {redirect_pc[31:2], 2'b00};
    assign w_misalign     = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign imem_addr      = word_index(r_pc, IMEM_WORDS);

    // Per-edge priority: redirect, then stall, then flush, then fetch
    always_comb begin
        w_pc_next = w_pc_plus4;
        w_bubble  = 1'b0;
        w_load    = 1'b0;
        if (redirect_valid) begin
            w_pc_next = w_redirect_tgt;
            w_bubble  = 1'b1;
        end else if (stall) begin
            w_pc_next = r_pc;
            w_bubble  = flush;
        end else if (flush) begin
            w_bubble  = 1'b1;
        end else begin
            w_load    = 1'b1;
        end
    end

    // Bundle the fetched word with its PC and PC+4
    always_comb begin
        w_d = '{
            instr: imem_data,
            pc:    r_pc,
            pc4:   w_pc_plus4,
            valid: 1'b1
        };
    end

    // Program counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // Sticky misaligned-target flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else if (w_misalign) begin
            r_misalign <= 1'b1;
        end
    end

    // Count real instructions written into IF/ID
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_count <= 32'h0;
        end else if (w_load) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    if_id_reg u_if_id (
        .clk    (clk),
        .rst    (rst),
        .load   (w_load),
        .bubble (w_bubble),
        .d      (w_d),
        .q      (w_q)
    );

    assign if_id_instr  = w_q.instr;
    assign if_id_pc     = w_q.pc;
    assign if_id_pc4    = w_q.pc4;
    assign if_id_valid  = w_q.valid;
    assign misalign_err = r_misalign;
    assign fetch_count  = r_fetch_count;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the 32-bit pipelined MIPS core, directly upstream of the 1K-word instruction memory. Holds the program counter and presents a word index to the memory's combinational read port. Captures the returned instruction, with its PC and PC+4, into the IF/ID pipeline register. Handles hazard-unit stalls, pipeline flushes, and branch/jump redirects.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; word-aligned.
- IMEM_WORDS, 1024, instruction memory depth in words; power of two.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- stall  in  1  hazard unit: hold PC and IF/ID.
- flush  in  1  replace the IF/ID contents with a bubble at the next edge.
- redirect_valid  in  1  a taken branch or jump is present this cycle.
- redirect_pc  in  32  branch/jump byte target.
- imem_addr  out  32  word index into the instruction memory (combinational).
- imem_data  in  32  instruction word returned combinationally by the memory.
- if_id_instr  out  32  registered instruction.
- if_id_pc  out  32  registered byte PC of if_id_instr.
- if_id_pc4  out  32  registered if_id_pc + 4.
- if_id_valid  out  1  1 = real instruction; 0 = bubble.
- misalign_err  out  1  sticky flag: a redirect target was not word-aligned.
- fetch_count  out  32  number of valid instructions written into IF/ID.

## Operation
- imem_addr = (pc >> 2) mod IMEM_WORDS, zero-extended to 32 bits. Out-of-range PCs wrap; no error.
- The PC register is 32 bits. pc + 4 wraps modulo 2^32, so 0xFFFF_FFFC becomes 0x0000_0000.
- Per-edge priority: rst, then redirect_valid, then stall, then flush, then normal.
  - **redirect_valid=1:**
    - pc <= {redirect_pc[31:2], 2'b00}.
    - IF/ID <= bubble, regardless of stall or flush.
    - If redirect_pc[1:0] != 0, misalign_err <= 1.
  - **stall=1, no redirect:**
    - pc holds.
    - If flush=1, IF/ID <= bubble.
    - Otherwise IF/ID holds, including if_id_valid.
  - **flush=1, no stall, no redirect:** pc <= pc + 4; IF/ID <= bubble.
  - **Normal:**
    - if_id_instr <= imem_data.
    - if_id_pc <= pc.
    - if_id_pc4 <= pc + 4.
    - if_id_valid <= 1.
    - pc <= pc + 4.
- Bubble: if_id_instr = 32'h0000_0000 (NOP), if_id_pc = 0, if_id_pc4 = 0, if_id_valid = 0.
- fetch_count increments by 1 on every edge that writes if_id_valid = 1. It wraps at 2^32.
- misalign_err is cleared only by rst.

## Timing
- Reset values (asynchronous, immediate on rst):
  - pc = RESET_PC.
  - if_id_instr = 0, if_id_pc = 0, if_id_pc4 = 0.
  - if_id_valid = 0.
  - misalign_err = 0.
  - fetch_count = 0.
- imem_addr is valid in the same cycle as pc. The memory read is combinational, so one fetch completes per cycle.
- Latency: an instruction at PC p appears in IF/ID one edge after pc = p.
- First edge after rst deasserts: IF/ID receives word RESET_PC>>2 with if_id_valid=1, and pc becomes RESET_PC+4.
- Redirect penalty: the edge carrying redirect inserts exactly one bubble. The target instruction appears at the following edge, unless stall is asserted then.
- rst asserted mid-stall or mid-redirect aborts the operation immediately; no partial state survives.

## Structure
- Shared package mips_pkg:
  - NOP_INSTR = 32'h0.
  - PC_W = 32.
  - Default RESET_PC and IMEM_WORDS.
  - Packed struct if_id_t {instr, pc, pc4, valid}.
- Sub-module if_id_reg:
  - Holds an if_id_t.
  - Inputs: load, bubble, d.
  - Asynchronous reset to bubble.
  - The fetch module owns the PC, priority logic and counters.

## Test plan
- **Reset release:** rst high for 3 cycles, then low, with imem_data = 32'h2008_0005 at word 0.
  - During rst: IF/ID shows a bubble and pc = 0.
  - First edge after release: if_id_instr = 32'h2008_0005, if_id_pc = 0, if_id_pc4 = 4, if_id_valid = 1, fetch_count = 1.
- **Sequential fetch:** 4 free-running edges.
  - imem_addr sequence is 0, 1, 2, 3.
  - if_id_pc sequence is 0x0, 0x4, 0x8, 0xC.
  - fetch_count = 4.
- **Stall:** stall=1 for 2 cycles while pc = 0x10.
  - pc and all IF/ID fields hold; fetch_count holds.
  - After release: if_id_pc = 0x10.
- **Redirect during stall:** redirect_valid=1, redirect_pc = 0x40, stall=1 in the same cycle.
  - Next edge: pc = 0x40, if_id_valid = 0.
  - Following edge: if_id_pc = 0x40, if_id_valid = 1.
- **Misaligned redirect:** redirect_pc = 0x0000_0106.
  - pc = 0x104, and misalign_err stays 1 until rst.
  - Separately, with IMEM_WORDS = 1024: pc = 0x1000 gives imem_addr = 0.
- **Flush, and PC wrap:**
  - flush=1 alone at pc = 0x20: IF/ID bubble and pc = 0x24.
  - Redirect to 0xFFFF_FFFC, then one free-running edge: pc = 0.
